// File: rtl/zap_tlb_assoc.sv
// zap_tlb_assoc: N-way set-associative TLB store for the ZAP MMU.
// Latency: lookup outputs are registered one cycle after i_va_nxt is sampled.
// Backpressure: none; fills and invalidates finish in one cycle, and i_clken only freezes the lookup outputs and counters.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_clken, i_va_nxt       lookup enable and lookup VA for the next cycle
//   i_fill*                 page-table-walker fill (VA, payload)
//   i_inv_all, i_inv_va     invalidate everything / invalidate by i_inv_addr
//   o_hit, o_rdata, o_way   registered lookup result (zeros on a miss)
//   o_hit_cnt, o_miss_cnt   saturating 16-bit lookup statistics
module zap_tlb_assoc #(
  parameter  int WAYS      = 4,
  parameter  int SETS      = 8,
  parameter  int INDEX_LSB = 12,
  parameter  int DATA_WDT  = 36,
  localparam int IW        = $clog2(SETS),
  localparam int WW        = $clog2(WAYS),
  localparam int TAG_WDT   = 32 - INDEX_LSB - IW
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clken,
  input  logic [31:0]         i_va_nxt,
  input  logic                i_fill,
  input  logic [31:0]         i_fill_va,
  input  logic [DATA_WDT-1:0] i_fill_data,
  input  logic                i_inv_all,
  input  logic                i_inv_va,
  input  logic [31:0]         i_inv_addr,
  output logic                o_hit,
  output logic [DATA_WDT-1:0] o_rdata,
  output logic [WW-1:0]       o_way,
  output logic [15:0]         o_hit_cnt,
  output logic [15:0]         o_miss_cnt
);

  // Entry storage: valid bits are reset, tags and payloads are not
  // (an entry's tag/payload is only ever observed while its valid bit is set).
  logic [WAYS-1:0]     r_valid [SETS];
  logic [TAG_WDT-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_WDT-1:0] r_data  [SETS][WAYS];
  logic [WW-1:0]       r_rr    [SETS];

  logic                r_hit;
  logic [DATA_WDT-1:0] r_rdata;
  logic [WW-1:0]       r_way;
  logic [15:0]         r_hit_cnt;
  logic [15:0]         r_miss_cnt;

  // Bits below the set index select a byte within a page and never matter.
  logic w_unused_offset;
  assign w_unused_offset = ^{i_va_nxt[INDEX_LSB-1:0], i_fill_va[INDEX_LSB-1:0],
                             i_inv_addr[INDEX_LSB-1:0]};

  // ---------------------------------------------------------------------------
  // Lookup compare (reads the pre-update array contents)
  // ---------------------------------------------------------------------------
  logic [IW-1:0]       w_lk_set;
  logic [TAG_WDT-1:0]  w_lk_tag;
  logic                w_lk_hit;
  logic [WW-1:0]       w_lk_way;
  logic [DATA_WDT-1:0] w_lk_data;

  assign w_lk_set = i_va_nxt[INDEX_LSB +: IW];
  assign w_lk_tag = i_va_nxt[31 -: TAG_WDT];

  // Scan from the top way down so that the lowest matching way wins if
  // several ways ever hold the same tag.
  always_comb begin
    w_lk_hit  = 1'b0;
    w_lk_way  = '0;
    w_lk_data = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_lk_set][w] && (r_tag[w_lk_set][w] == w_lk_tag)) begin
        w_lk_hit  = 1'b1;
        w_lk_way  = WW'(w);
        w_lk_data = r_data[w_lk_set][w];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fill victim selection: matching tag, else first free way, else round-robin
  // ---------------------------------------------------------------------------
  logic [IW-1:0]      w_fl_set;
  logic [TAG_WDT-1:0] w_fl_tag;
  logic               w_fl_match;
  logic [WW-1:0]      w_fl_match_way;
  logic               w_fl_free;
  logic [WW-1:0]      w_fl_free_way;
  logic [WW-1:0]      w_fl_way;
  logic               w_fl_adv_rr;

  assign w_fl_set = i_fill_va[INDEX_LSB +: IW];
  assign w_fl_tag = i_fill_va[31 -: TAG_WDT];

  always_comb begin
    w_fl_match     = 1'b0;
    w_fl_match_way = '0;
    w_fl_free      = 1'b0;
    w_fl_free_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_fl_set][w] && (r_tag[w_fl_set][w] == w_fl_tag)) begin
        w_fl_match     = 1'b1;
        w_fl_match_way = WW'(w);
      end
      if (!r_valid[w_fl_set][w]) begin
        w_fl_free     = 1'b1;
        w_fl_free_way = WW'(w);
      end
    end
  end

  // The round-robin pointer only moves when it actually picked the victim.
  assign w_fl_adv_rr = !w_fl_match && !w_fl_free;
  assign w_fl_way    = w_fl_match ? w_fl_match_way :
                       w_fl_free  ? w_fl_free_way  : r_rr[w_fl_set];

  // ---------------------------------------------------------------------------
  // Invalidate-by-VA: every way whose tag matches, valid or not
  // ---------------------------------------------------------------------------
  logic [IW-1:0]      w_inv_set;
  logic [TAG_WDT-1:0] w_inv_tag;
  logic [WAYS-1:0]    w_inv_mask;

  assign w_inv_set = i_inv_addr[INDEX_LSB +: IW];
  assign w_inv_tag = i_inv_addr[31 -: TAG_WDT];

  always_comb begin
    w_inv_mask = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_inv_mask[w] = (r_tag[w_inv_set][w] == w_inv_tag);
    end
  end

  // ---------------------------------------------------------------------------
  // Array update: reset > inv_all > inv_va > fill, losers dropped entirely
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset || i_inv_all) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (i_inv_va) begin
      r_valid[w_inv_set] <= r_valid[w_inv_set] & ~w_inv_mask;
    end else if (i_fill) begin
      r_valid[w_fl_set][w_fl_way] <= 1'b1;
      r_tag[w_fl_set][w_fl_way]   <= w_fl_tag;
      r_data[w_fl_set][w_fl_way]  <= i_fill_data;
      // WAYS is a power of two, so the natural WW-bit wrap is the modulo.
      if (w_fl_adv_rr) begin
        r_rr[w_fl_set] <= r_rr[w_fl_set] + WW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered lookup result and saturating counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hit      <= 1'b0;
      r_rdata    <= '0;
      r_way      <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (i_clken) begin
      r_hit   <= w_lk_hit;
      r_rdata <= w_lk_data;
      r_way   <= w_lk_way;
      if (w_lk_hit) begin
        if (r_hit_cnt != 16'hFFFF) begin
          r_hit_cnt <= r_hit_cnt + 16'd1;
        end
      end else begin
        if (r_miss_cnt != 16'hFFFF) begin
          r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end
    end
  end

  assign o_hit      = r_hit;
  assign o_rdata    = r_rdata;
  assign o_way      = r_way;
  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_zap_tlb_assoc.sv
module tb_zap_tlb_assoc;
  localparam int WAYS = 4, SETS = 8, INDEX_LSB = 12, DATA_WDT = 36;

  logic                i_clk = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_clken = 1'b0;
  logic [31:0]         i_va_nxt = '0;
  logic                i_fill = 1'b0;
  logic [31:0]         i_fill_va = '0;
  logic [DATA_WDT-1:0] i_fill_data = '0;
  logic                i_inv_all = 1'b0;
  logic                i_inv_va = 1'b0;
  logic [31:0]         i_inv_addr = '0;
  logic                o_hit;
  logic [DATA_WDT-1:0] o_rdata;
  logic [1:0]          o_way;
  logic [15:0]         o_hit_cnt;
  logic [15:0]         o_miss_cnt;

  always #5 i_clk = ~i_clk;

  zap_tlb_assoc #(.WAYS(WAYS), .SETS(SETS), .INDEX_LSB(INDEX_LSB), .DATA_WDT(DATA_WDT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clken(i_clken), .i_va_nxt(i_va_nxt),
    .i_fill(i_fill), .i_fill_va(i_fill_va), .i_fill_data(i_fill_data),
    .i_inv_all(i_inv_all), .i_inv_va(i_inv_va), .i_inv_addr(i_inv_addr),
    .o_hit(o_hit), .o_rdata(o_rdata), .o_way(o_way),
    .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a table of (valid, tag, payload) per set and way, plus a
  // replacement cursor per set. Tag is the VA divided by the set-span size.
  bit                m_vld [SETS][WAYS];
  int                m_tag [SETS][WAYS];
  logic [DATA_WDT-1:0] m_dat [SETS][WAYS];
  int                m_rr  [SETS];
  logic              e_hit = 1'b0;
  logic [1:0]        e_way = '0;
  logic [DATA_WDT-1:0] e_rdata = '0;
  logic [15:0]       e_hc = '0;
  logic [15:0]       e_mc = '0;

  function automatic int set_of(input logic [31:0] va);
    return int'((va / 32'd4096) % SETS);
  endfunction

  function automatic int tag_of(input logic [31:0] va);
    return int'(va / (32'd4096 * SETS));
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
    end
  endtask

  // Applies one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int s, t, hw, victim;
    if (i_reset) begin
      model_clear();
      e_hit = 0; e_way = 0; e_rdata = 0; e_hc = 0; e_mc = 0;
      return;
    end
    if (i_clken) begin
      s = set_of(i_va_nxt); t = tag_of(i_va_nxt); hw = -1;
      for (int w = 0; w < WAYS; w++)
        if (hw < 0 && m_vld[s][w] && m_tag[s][w] == t) hw = w;
      e_hit   = (hw >= 0);
      e_way   = (hw >= 0) ? 2'(hw) : 2'd0;
      e_rdata = (hw >= 0) ? m_dat[s][hw] : '0;
      if (hw >= 0) begin if (e_hc != 16'hFFFF) e_hc = e_hc + 1; end
      else begin if (e_mc != 16'hFFFF) e_mc = e_mc + 1; end
    end
    if (i_inv_all) begin
      model_clear();
    end else if (i_inv_va) begin
      s = set_of(i_inv_addr); t = tag_of(i_inv_addr);
      for (int w = 0; w < WAYS; w++) if (m_tag[s][w] == t) m_vld[s][w] = 1'b0;
    end else if (i_fill) begin
      s = set_of(i_fill_va); t = tag_of(i_fill_va); victim = -1;
      for (int w = 0; w < WAYS; w++)
        if (victim < 0 && m_vld[s][w] && m_tag[s][w] == t) victim = w;
      for (int w = 0; w < WAYS; w++)
        if (victim < 0 && !m_vld[s][w]) victim = w;
      if (victim < 0) begin
        victim = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_vld[s][victim] = 1'b1;
      m_tag[s][victim] = t;
      m_dat[s][victim] = i_fill_data;
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic clear_ops();
    i_fill = 0; i_inv_all = 0; i_inv_va = 0; i_reset = 0;
  endtask

  task automatic do_fill(input logic [31:0] va, input logic [DATA_WDT-1:0] d);
    i_fill = 1; i_fill_va = va; i_fill_data = d;
    step();
    i_fill = 0;
  endtask

  task automatic test_reset();
    i_reset = 1;
    step(); step();
    vectors++;
    if ({o_hit, o_way, o_rdata, o_hit_cnt, o_miss_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset: hit=%0d way=%0d data=%h hc=%0d mc=%0d, expected all zero",
               o_hit, o_way, o_rdata, o_hit_cnt, o_miss_cnt);
    end
    i_reset = 0;
  endtask

  task automatic test_first_miss();
    i_clken = 1; i_va_nxt = 32'h0000_3000;
    step();
    vectors++;
    if (o_hit !== 1'b0 || o_rdata !== '0 || o_miss_cnt !== 16'd1 || o_hit_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL first_miss: hit=%0d data=%h mc=%0d hc=%0d, expected 0 0 1 0",
               o_hit, o_rdata, o_miss_cnt, o_hit_cnt);
    end
  endtask

  task automatic test_fill_then_hit();
    i_va_nxt = 32'h0000_3000;
    do_fill(32'h0000_3000, 36'hA5);
    vectors++;
    if (o_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle_fill: hit=%0d, expected 0", o_hit);
    end
    i_va_nxt = 32'h0000_3ABC;
    step();
    vectors++;
    if (o_hit !== 1'b1 || o_rdata !== 36'hA5 || o_way !== 2'd0) begin
      miscompares++;
      $display("FAIL fill_hit: hit=%0d data=%h way=%0d, expected 1 a5 0", o_hit, o_rdata, o_way);
    end
  endtask

  task automatic test_replacement();
    logic [31:0] vas [5];
    vas[0] = 32'h0000_3000; vas[1] = 32'h0000_B000; vas[2] = 32'h0001_3000;
    vas[3] = 32'h0001_B000; vas[4] = 32'h0002_3000;
    for (int i = 0; i < 5; i++) do_fill(vas[i], 36'h100 + 36'(i));
    for (int i = 0; i < 5; i++) begin
      i_va_nxt = vas[i];
      step();
      vectors++;
      // Expected: entry 0 was evicted by entry 4, entries 1..3 sit in ways 1..3.
      if (o_hit !== (i != 0) || (i != 0 && (o_way !== ((i == 4) ? 2'd0 : 2'(i)) ||
          o_rdata !== 36'h100 + 36'(i)))) begin
        miscompares++;
        $display("FAIL replace[%0d]: hit=%0d way=%0d data=%h", i, o_hit, o_way, o_rdata);
      end
    end
  endtask

  task automatic test_refill();
    do_fill(32'h0000_B000, 36'h5A);
    i_va_nxt = 32'h0000_B123;
    step();
    vectors++;
    if (o_hit !== 1'b1 || o_way !== 2'd1 || o_rdata !== 36'h5A) begin
      miscompares++;
      $display("FAIL refill: hit=%0d way=%0d data=%h, expected 1 1 5a", o_hit, o_way, o_rdata);
    end
  endtask

  task automatic test_invalidate();
    logic [31:0] vas [5];
    i_inv_va = 1; i_inv_addr = 32'h0000_B000;
    i_fill = 1; i_fill_va = 32'h0003_3000; i_fill_data = 36'hBAD;
    step();
    clear_ops();
    vas[0] = 32'h0000_B000; vas[1] = 32'h0003_3000; vas[2] = 32'h0001_3000;
    for (int i = 0; i < 3; i++) begin
      i_va_nxt = vas[i];
      step();
      vectors++;
      if (o_hit !== (i == 2) || (i == 2 && o_way !== 2'd2)) begin
        miscompares++;
        $display("FAIL inv_va[%0d]: hit=%0d way=%0d", i, o_hit, o_way);
      end
    end
    i_inv_all = 1;
    step();
    clear_ops();
    i_va_nxt = 32'h0002_3000;
    step();
    vectors++;
    if (o_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL inv_all: hit=%0d, expected 0", o_hit);
    end
    // Five fresh tags: the fifth must evict way 0 if the pointer was cleared.
    for (int i = 0; i < 5; i++) vas[i] = 32'h0004_3000 + 32'(i) * 32'h0001_0000;
    for (int i = 0; i < 5; i++) do_fill(vas[i], 36'h200 + 36'(i));
    i_va_nxt = vas[4];
    step();
    vectors++;
    if (o_hit !== 1'b1 || o_way !== 2'd0 || o_rdata !== 36'h204) begin
      miscompares++;
      $display("FAIL rr_cleared: hit=%0d way=%0d data=%h, expected 1 0 204", o_hit, o_way, o_rdata);
    end
  endtask

  task automatic test_clken_hold();
    logic [DATA_WDT-1:0] s_data;
    logic [15:0] s_hc, s_mc;
    logic s_hit;
    logic [1:0] s_way;
    i_va_nxt = 32'h0005_3000;
    step();
    s_hit = e_hit; s_way = e_way; s_data = e_rdata; s_hc = e_hc; s_mc = e_mc;
    i_clken = 0;
    for (int i = 0; i < 3; i++) begin
      i_va_nxt = $urandom;
      if (i == 1) begin i_fill = 1; i_fill_va = 32'h0000_5000; i_fill_data = 36'h77; end
      step();
      i_fill = 0;
      vectors++;
      if ({o_hit, o_way, o_rdata, o_hit_cnt, o_miss_cnt} !== {s_hit, s_way, s_data, s_hc, s_mc}) begin
        miscompares++;
        $display("FAIL clken_hold[%0d]: hit=%0d way=%0d data=%h hc=%0d mc=%0d, expected %0d %0d %h %0d %0d",
                 i, o_hit, o_way, o_rdata, o_hit_cnt, o_miss_cnt, s_hit, s_way, s_data, s_hc, s_mc);
      end
    end
    i_clken = 1; i_va_nxt = 32'h0000_5FFF;
    step();
    vectors++;
    if (o_hit !== 1'b1 || o_rdata !== 36'h77) begin
      miscompares++;
      $display("FAIL fill_while_stalled: hit=%0d data=%h, expected 1 77", o_hit, o_rdata);
    end
  endtask

  function automatic logic [31:0] rand_va();
    return 32'($urandom_range(0, 5)) * 32'h8000 + 32'($urandom_range(0, 2)) * 32'h1000 +
           32'($urandom_range(0, 4095));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      i_reset    = ($urandom_range(0, 199) == 0);
      i_inv_all  = ($urandom_range(0, 39) == 0);
      i_inv_va   = ($urandom_range(0, 5) == 0);
      i_fill     = ($urandom_range(0, 1) == 0);
      i_clken    = ($urandom_range(0, 4) != 0);
      i_va_nxt   = rand_va();
      i_fill_va  = rand_va();
      i_inv_addr = rand_va();
      i_fill_data = {4'($urandom), 32'($urandom)};
      step();
      vectors++;
      if ({o_hit, o_way, o_rdata, o_hit_cnt, o_miss_cnt} !== {e_hit, e_way, e_rdata, e_hc, e_mc}) begin
        miscompares++;
        $display("FAIL random[%0d]: hit=%0d way=%0d data=%h hc=%0d mc=%0d, expected %0d %0d %h %0d %0d",
                 i, o_hit, o_way, o_rdata, o_hit_cnt, o_miss_cnt, e_hit, e_way, e_rdata, e_hc, e_mc);
      end
    end
    clear_ops();
    i_clken = 1;
  endtask

  task automatic test_saturate_and_reset();
    do_fill(32'h0000_7000, 36'h3C);
    i_va_nxt = 32'h0000_7000;
    for (int i = 0; i < 70000; i++) step();
    vectors++;
    if (o_hit_cnt !== 16'hFFFF || o_hit !== 1'b1 ||
        {o_way, o_rdata, o_miss_cnt} !== {e_way, e_rdata, e_mc}) begin
      miscompares++;
      $display("FAIL saturate: hc=%h hit=%0d way=%0d data=%h mc=%0d, expected ffff 1 %0d %h %0d",
               o_hit_cnt, o_hit, o_way, o_rdata, o_miss_cnt, e_way, e_rdata, e_mc);
    end
    i_reset = 1;
    step();
    i_reset = 0;
    vectors++;
    if ({o_hit, o_way, o_rdata, o_hit_cnt, o_miss_cnt} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: hit=%0d way=%0d data=%h hc=%0d mc=%0d, expected all zero",
               o_hit, o_way, o_rdata, o_hit_cnt, o_miss_cnt);
    end
    step();
    vectors++;
    if (o_hit !== 1'b0 || o_miss_cnt !== 16'd1 || o_hit_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL post_reset_lookup: hit=%0d mc=%0d hc=%0d, expected 0 1 0", o_hit, o_miss_cnt, o_hit_cnt);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_miss();
    test_fill_then_hit();
    test_replacement();
    test_refill();
    test_invalidate();
    test_clken_hold();
    test_random();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
